sif_bus_arbiter: RTL and testbench
==================================

# sif_bus_arbiter

Two-requester arbiter and sequencer for the SIF register bus. Shares one target register port between the `xa` requester (read/write) and the `wa` requester (write-only). Uses round-robin arbitration, a strobe/ack handshake and a configurable read-return latency. It sits between the SIF agents/bus masters and the register file.

## Interface
- `AW`, 16, address width.
- `DW`, 16, data width.
- `RD_LAT`, 1, target read latency in cycles, legal range 1..4.

- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `xa_addr_i` in AW: xa address.
- `xa_data_wr_i` in DW: xa write data.
- `xa_rd_s_i` in 1: xa read strobe, held until ack.
- `xa_wr_s_i` in 1: xa write strobe, held until ack.
- `xa_ack_o` out 1: one-cycle xa completion pulse.
- `xa_data_rd_o` out DW: last xa read data, held until the next xa read completes.
- `wa_addr_i` in AW: wa address.
- `wa_data_wr_i` in DW: wa write data.
- `wa_wr_s_i` in 1: wa write strobe, held until ack.
- `wa_ack_o` out 1: one-cycle wa completion pulse.
- `t_addr_o` out AW: target address.
- `t_data_wr_o` out DW: target write data.
- `t_wr_s_o` out 1: target write strobe, one-cycle pulse.
- `t_rd_s_o` out 1: target read strobe, one-cycle pulse.
- `t_data_rd_i` in DW: target read data, valid exactly RD_LAT cycles after the `t_rd_s_o` cycle.
- `busy_o` out 1: high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, ISSUE, RD_WAIT.
- **IDLE:** samples requests.
  - xa request = `xa_rd_s_i | xa_wr_s_i`; wa request = `wa_wr_s_i`.
  - One request → grant it. Both requests → grant the requester not granted last.
  - `last_grant` resets to wa, so xa wins the first tie.
  - On grant: latch addr, data and op, update `last_grant`, go to ISSUE.
- **ISSUE** (one cycle):
  - Drive `t_addr_o`/`t_data_wr_o` from the latch.
  - Write: pulse `t_wr_s_o` and the granted ack in the same cycle, then go to IDLE.
  - Read: pulse `t_rd_s_o`, load the latency counter with RD_LAT, go to RD_WAIT.
- **RD_WAIT:**
  - Counter decrements each cycle.
  - In the cycle the counter reaches 0, capture `t_data_rd_i`.
  - In the next cycle: `xa_data_rd_o` updates, `xa_ack_o` pulses, go to IDLE.
- `xa_rd_s_i` and `xa_wr_s_i` both high → treated as a write. The ack is a normal write ack; `xa_data_rd_o` is unchanged.
- When no target strobe is active, `t_addr_o`, `t_data_wr_o`, `t_wr_s_o` and `t_rd_s_o` are 0.
- A request arriving in any non-IDLE state waits. The requester must keep its strobe and addr/data stable until its ack.
- A strobe still high in the cycle after its ack is a new transaction.
- Width rule: addr/data pass through unmodified; no arithmetic on the datapath. The counter is 3 bits.

## Timing
- **Reset** (`rst_i` high at a rising edge), takes effect next cycle:
  - state IDLE, `last_grant` wa, counter 0.
  - All outputs 0, including `xa_data_rd_o` and `busy_o`.
- **Reset mid-operation:** the pending transaction is abandoned. No ack is issued and `t_data_rd_i` is not captured.
- **Write:** request first high in IDLE at cycle N → `t_wr_s_o` + ack at N+1 → IDLE at N+2.
  - Maximum sustained write rate is one per 2 cycles.
- **Read:** request at cycle N → `t_rd_s_o` at N+1 → capture at N+1+RD_LAT → `xa_ack_o` and new `xa_data_rd_o` at N+2+RD_LAT.
- `busy_o` is high from N+1 until the cycle the ack is issued, inclusive.
- An ack never asserts on both requesters in the same cycle.
- `t_wr_s_o` and `t_rd_s_o` are never high together.

## Test plan
- **Single write** (RD_LAT=1): xa writes addr 0x0010, data 0xBEEF, strobe at cycle 0 → at cycle 1, `t_wr_s_o`=1, `t_addr_o`=0x0010, `t_data_wr_o`=0xBEEF, `xa_ack_o`=1; at cycle 2, `busy_o`=0.
- **Read latency** (RD_LAT=2): xa reads addr 0x0020 at cycle 0; target drives 0x1234 at cycle 3 → `t_rd_s_o` at cycle 1; `xa_ack_o`=1 and `xa_data_rd_o`=0x1234 at cycle 4; `busy_o` high in cycles 1–4.
- **Tie after reset:** xa writes 0x0001←0xAAAA and wa writes 0x0002←0x5555, both strobed at cycle 0 and held until ack → xa issued and acked at cycle 1; wa issued and acked at cycle 3.
  - Repeat the tie → xa wins again, since `last_grant` is wa.
- **Illegal double strobe:** `xa_rd_s_i`=`xa_wr_s_i`=1, addr 0x0030, data 0x0F0F → write issued at cycle 1; `t_rd_s_o` stays 0; `xa_data_rd_o` unchanged.
- **Reset mid-read** (RD_LAT=4): xa read at cycle 0, `rst_i` high at cycle 3 → no `xa_ack_o` ever; from cycle 4, all outputs 0 and state IDLE; a new wa write at cycle 5 is acked at cycle 6.
- **Held strobe:** `wa_wr_s_i` held high for 6 cycles with fixed addr/data → `wa_ack_o` and `t_wr_s_o` at cycles 1, 3, 5.

Source files
------------

// File: rtl/sif_bus_arbiter.sv
// Round-robin arbiter/sequencer sharing one SIF target register port between
// the read/write xa requester and the write-only wa requester.
module sif_bus_arbiter #(
    parameter int AW     = 16,
    parameter int DW     = 16,
    parameter int RD_LAT = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [AW-1:0] xa_addr_i,
    input  logic [DW-1:0] xa_data_wr_i,
    input  logic          xa_rd_s_i,
    input  logic          xa_wr_s_i,
    output logic          xa_ack_o,
    output logic [DW-1:0] xa_data_rd_o,
    input  logic [AW-1:0] wa_addr_i,
    input  logic [DW-1:0] wa_data_wr_i,
    input  logic          wa_wr_s_i,
    output logic          wa_ack_o,
    output logic [AW-1:0] t_addr_o,
    output logic [DW-1:0] t_data_wr_o,
    output logic          t_wr_s_o,
    output logic          t_rd_s_o,
    input  logic [DW-1:0] t_data_rd_i,
    output logic          busy_o
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_RD_WAIT = 2'd2;
    localparam logic [2:0] LAT3      = 3'(RD_LAT);

    logic [1:0]    state_q, state_d;
    logic          last_wa_q, last_wa_d;
    logic          gnt_wa_q, gnt_wa_d;
    logic          op_rd_q, op_rd_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          xa_req, wa_req, issue;

    assign xa_req = xa_rd_s_i | xa_wr_s_i;
    assign wa_req = wa_wr_s_i;
    assign issue  = (state_q == S_ISSUE);

    always_comb begin
        state_d   = state_q;
        last_wa_d = last_wa_q;
        gnt_wa_d  = gnt_wa_q;
        op_rd_d   = op_rd_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        case (state_q)
            S_IDLE: begin
                // On a tie the requester that did not win last time is served.
                if (xa_req && (!wa_req || last_wa_q)) begin
                    gnt_wa_d  = 1'b0;
                    last_wa_d = 1'b0;
                    op_rd_d   = xa_rd_s_i & ~xa_wr_s_i;
                    addr_d    = xa_addr_i;
                    wdata_d   = xa_data_wr_i;
                    state_d   = S_ISSUE;
                end else if (wa_req) begin
                    gnt_wa_d  = 1'b1;
                    last_wa_d = 1'b1;
                    op_rd_d   = 1'b0;
                    addr_d    = wa_addr_i;
                    wdata_d   = wa_data_wr_i;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (op_rd_q) begin
                    cnt_d   = LAT3;
                    state_d = S_RD_WAIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD_WAIT: begin
                // Count 1 marks the cycle the target data is valid; count 0 is the ack cycle.
                if (cnt_q == 3'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        rdata_d = t_data_rd_i;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            last_wa_q <= 1'b1;
            gnt_wa_q  <= 1'b0;
            op_rd_q   <= 1'b0;
            cnt_q     <= 3'd0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            last_wa_q <= last_wa_d;
            gnt_wa_q  <= gnt_wa_d;
            op_rd_q   <= op_rd_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
        end
    end

    // Address/data latches are only observed through the ISSUE-gated outputs.
    always_ff @(posedge clk_i) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    assign t_wr_s_o     = issue & ~op_rd_q;
    assign t_rd_s_o     = issue & op_rd_q;
    assign t_addr_o     = issue ? addr_q : '0;
    assign t_data_wr_o  = issue ? wdata_q : '0;
    assign xa_ack_o     = (issue & ~op_rd_q & ~gnt_wa_q) |
                          ((state_q == S_RD_WAIT) && (cnt_q == 3'd0));
    assign wa_ack_o     = issue & gnt_wa_q;
    assign xa_data_rd_o = rdata_q;
    assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_sif_bus_arbiter.sv
// Bench for sif_bus_arbiter: three instances (RD_LAT 1, 2, 4) share stimulus;
// per-cycle vector table plus hand-written read/reset sequences and a target-access scoreboard.
module tb_sif_bus_arbiter;

    typedef struct packed {
        logic        t_wr;
        logic        t_rd;
        logic [15:0] addr;
        logic [15:0] wdat;
        logic        xa_ack;
        logic        wa_ack;
        logic        busy;
        logic [15:0] xrd;
    } outs_t;

    typedef struct {
        logic        xa_rd;
        logic        xa_wr;
        logic [15:0] xa_addr;
        logic [15:0] xa_data;
        logic        wa_wr;
        logic [15:0] wa_addr;
        logic [15:0] wa_data;
        outs_t       exp;
    } vec_t;

    typedef struct packed {
        logic        rd;
        logic [15:0] addr;
        logic [15:0] data;
    } acc_t;

    localparam int LAT [3] = '{1, 2, 4};

    logic        clk, rst;
    logic [15:0] xa_addr, xa_data, wa_addr, wa_data, rd_value;
    logic        xa_wr, wa_wr;
    logic        xa_rd_s [3];
    logic        hold [3];
    logic        xa_ack [3], wa_ack [3], t_wr [3], t_rd [3], busy [3];
    logic [15:0] xa_rdat [3], t_addr [3], t_wdat [3], t_rdata [3];
    logic [3:0]  hist [3];

    int   checks = 0;
    int   errors = 0;
    acc_t sbq [$];
    vec_t tbl [23];

    sif_bus_arbiter #(.AW(16), .DW(16), .RD_LAT(1)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .xa_addr_i(xa_addr), .xa_data_wr_i(xa_data),
        .xa_rd_s_i(xa_rd_s[0]), .xa_wr_s_i(xa_wr), .xa_ack_o(xa_ack[0]), .xa_data_rd_o(xa_rdat[0]),
        .wa_addr_i(wa_addr), .wa_data_wr_i(wa_data), .wa_wr_s_i(wa_wr), .wa_ack_o(wa_ack[0]),
        .t_addr_o(t_addr[0]), .t_data_wr_o(t_wdat[0]), .t_wr_s_o(t_wr[0]), .t_rd_s_o(t_rd[0]),
        .t_data_rd_i(t_rdata[0]), .busy_o(busy[0]));

    sif_bus_arbiter #(.AW(16), .DW(16), .RD_LAT(2)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .xa_addr_i(xa_addr), .xa_data_wr_i(xa_data),
        .xa_rd_s_i(xa_rd_s[1]), .xa_wr_s_i(xa_wr), .xa_ack_o(xa_ack[1]), .xa_data_rd_o(xa_rdat[1]),
        .wa_addr_i(wa_addr), .wa_data_wr_i(wa_data), .wa_wr_s_i(wa_wr), .wa_ack_o(wa_ack[1]),
        .t_addr_o(t_addr[1]), .t_data_wr_o(t_wdat[1]), .t_wr_s_o(t_wr[1]), .t_rd_s_o(t_rd[1]),
        .t_data_rd_i(t_rdata[1]), .busy_o(busy[1]));

    sif_bus_arbiter #(.AW(16), .DW(16), .RD_LAT(4)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .xa_addr_i(xa_addr), .xa_data_wr_i(xa_data),
        .xa_rd_s_i(xa_rd_s[2]), .xa_wr_s_i(xa_wr), .xa_ack_o(xa_ack[2]), .xa_data_rd_o(xa_rdat[2]),
        .wa_addr_i(wa_addr), .wa_data_wr_i(wa_data), .wa_wr_s_i(wa_wr), .wa_ack_o(wa_ack[2]),
        .t_addr_o(t_addr[2]), .t_data_wr_o(t_wdat[2]), .t_wr_s_o(t_wr[2]), .t_rd_s_o(t_rd[2]),
        .t_data_rd_i(t_rdata[2]), .busy_o(busy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Target model: read data valid only RD_LAT cycles after the read strobe, garbage otherwise.
    always @(posedge clk) begin
        for (int g = 0; g < 3; g++) hist[g] <= {hist[g][2:0], t_rd[g]};
    end
    assign t_rdata[0] = hist[0][0] ? rd_value : 16'hDEAD;
    assign t_rdata[1] = hist[1][1] ? rd_value : 16'hDEAD;
    assign t_rdata[2] = hist[2][3] ? rd_value : 16'hDEAD;

    // Scoreboard on the RD_LAT=2 instance: every target strobe must match the next expected access.
    always @(negedge clk) begin
        if (!rst && (t_wr[1] || t_rd[1])) begin
            acc_t a, e;
            a = {t_rd[1], t_addr[1], t_wdat[1]};
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got %h required no access", a);
            end else begin
                e = sbq.pop_front();
                if (a !== e) begin
                    errors++;
                    $display("FAIL sb_access: got %h required %h", a, e);
                end
            end
        end
    end

    function automatic outs_t o_idle(input logic [15:0] xrd);
        outs_t o = '0;
        o.xrd = xrd;
        return o;
    endfunction

    function automatic outs_t o_wr(input logic [15:0] a, input logic [15:0] d,
                                   input logic is_xa, input logic [15:0] xrd);
        outs_t o = '0;
        o.t_wr = 1'b1; o.addr = a; o.wdat = d;
        o.xa_ack = is_xa; o.wa_ack = ~is_xa; o.busy = 1'b1; o.xrd = xrd;
        return o;
    endfunction

    function automatic vec_t v(input logic xr, input logic xw, input logic [15:0] xad,
                               input logic [15:0] xdt, input logic ww, input logic [15:0] wad,
                               input logic [15:0] wdt, input outs_t e);
        vec_t r;
        r.xa_rd = xr; r.xa_wr = xw; r.xa_addr = xad; r.xa_data = xdt;
        r.wa_wr = ww; r.wa_addr = wad; r.wa_data = wdt; r.exp = e;
        return r;
    endfunction

    function automatic outs_t get_o(input int g);
        outs_t o;
        o.t_wr = t_wr[g]; o.t_rd = t_rd[g]; o.addr = t_addr[g]; o.wdat = t_wdat[g];
        o.xa_ack = xa_ack[g]; o.wa_ack = wa_ack[g]; o.busy = busy[g]; o.xrd = xa_rdat[g];
        return o;
    endfunction

    task automatic chk(input string nm, input int g, input outs_t e);
        outs_t a;
        a = get_o(g);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s dut%0d: got %h required %h", nm, g, a, e);
        end
    endtask

    task automatic push(input logic rd, input logic [15:0] a, input logic [15:0] d);
        acc_t e;
        e = {rd, a, d};
        sbq.push_back(e);
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            @(posedge clk);
            #1;
            for (int g = 0; g < 3; g++) xa_rd_s[g] = tbl[i].xa_rd;
            xa_wr   = tbl[i].xa_wr;
            xa_addr = tbl[i].xa_addr;
            xa_data = tbl[i].xa_data;
            wa_wr   = tbl[i].wa_wr;
            wa_addr = tbl[i].wa_addr;
            wa_data = tbl[i].wa_data;
            @(negedge clk);
            for (int g = 0; g < 3; g++) chk($sformatf("row%0d", i), g, tbl[i].exp);
        end
    endtask

    initial begin
        outs_t e;
        // Tie after reset, twice: xa wins both times
        tbl[0]  = v(0, 1, 16'h0001, 16'hAAAA, 1, 16'h0002, 16'h5555, o_idle(16'h0));
        tbl[1]  = v(0, 1, 16'h0001, 16'hAAAA, 1, 16'h0002, 16'h5555, o_wr(16'h0001, 16'hAAAA, 1, 16'h0));
        tbl[2]  = v(0, 0, 16'h0000, 16'h0000, 1, 16'h0002, 16'h5555, o_idle(16'h0));
        tbl[3]  = v(0, 0, 16'h0000, 16'h0000, 1, 16'h0002, 16'h5555, o_wr(16'h0002, 16'h5555, 0, 16'h0));
        tbl[4]  = v(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, o_idle(16'h0));
        for (int i = 5; i < 10; i++) tbl[i] = tbl[i-5];
        // Single xa write
        tbl[10] = v(0, 1, 16'h0010, 16'hBEEF, 0, 16'h0000, 16'h0000, o_idle(16'h0));
        tbl[11] = v(0, 1, 16'h0010, 16'hBEEF, 0, 16'h0000, 16'h0000, o_wr(16'h0010, 16'hBEEF, 1, 16'h0));
        tbl[12] = v(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, o_idle(16'h0));
        // Double strobe after a read of 0x1234: write issued, read data held
        tbl[13] = v(1, 1, 16'h0030, 16'h0F0F, 0, 16'h0000, 16'h0000, o_idle(16'h1234));
        tbl[14] = v(1, 1, 16'h0030, 16'h0F0F, 0, 16'h0000, 16'h0000, o_wr(16'h0030, 16'h0F0F, 1, 16'h1234));
        tbl[15] = v(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, o_idle(16'h1234));
        // wa strobe held six cycles: three back-to-back writes
        for (int i = 16; i < 22; i++)
            tbl[i] = v(0, 0, 16'h0000, 16'h0000, 1, 16'h0044, 16'h1357,
                       ((i - 16) % 2 == 1) ? o_wr(16'h0044, 16'h1357, 0, 16'h1234) : o_idle(16'h1234));
        tbl[22] = v(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, o_idle(16'h1234));

        rst = 1'b1;
        for (int g = 0; g < 3; g++) begin xa_rd_s[g] = 1'b1; hold[g] = 1'b0; end
        xa_wr = 1'b1; wa_wr = 1'b1;
        xa_addr = 16'h1111; xa_data = 16'h2222; wa_addr = 16'h3333; wa_data = 16'h4444;
        rd_value = 16'h0000;

        // Reset with strobes asserted: outputs stay quiet
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            @(negedge clk);
            for (int g = 0; g < 3; g++) chk("reset", g, o_idle(16'h0));
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int g = 0; g < 3; g++) xa_rd_s[g] = 1'b0;
        xa_wr = 1'b0; wa_wr = 1'b0;
        @(negedge clk);
        for (int g = 0; g < 3; g++) chk("reset_release", g, o_idle(16'h0));

        push(0, 16'h0001, 16'hAAAA); push(0, 16'h0002, 16'h5555);
        push(0, 16'h0001, 16'hAAAA); push(0, 16'h0002, 16'h5555);
        push(0, 16'h0010, 16'hBEEF);
        run_rows(0, 12);

        // xa read of 0x0020 returning 0x1234, each instance with its own latency
        push(1, 16'h0020, 16'h0000);
        rd_value = 16'h1234;
        for (int g = 0; g < 3; g++) hold[g] = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(posedge clk);
            #1;
            xa_addr = 16'h0020; xa_data = 16'h0000; xa_wr = 1'b0; wa_wr = 1'b0;
            for (int g = 0; g < 3; g++) xa_rd_s[g] = hold[g];
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                e        = '0;
                e.t_rd   = (c == 1);
                e.addr   = (c == 1) ? 16'h0020 : 16'h0000;
                e.xa_ack = (c == 2 + LAT[g]);
                e.busy   = (c >= 1) && (c <= 2 + LAT[g]);
                e.xrd    = (c >= 2 + LAT[g]) ? 16'h1234 : 16'h0000;
                chk($sformatf("read_c%0d", c), g, e);
                if (xa_ack[g]) hold[g] = 1'b0;
            end
        end

        push(0, 16'h0030, 16'h0F0F);
        push(0, 16'h0044, 16'h1357); push(0, 16'h0044, 16'h1357); push(0, 16'h0044, 16'h1357);
        run_rows(13, 22);

        // Reset in the middle of a read; a wa write afterwards behaves normally
        push(1, 16'h0040, 16'h0000);
        push(0, 16'h0050, 16'h2468);
        rd_value = 16'h7777;
        for (int g = 0; g < 3; g++) hold[g] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            rst = (c == 3);
            if (c == 3) for (int g = 0; g < 3; g++) hold[g] = 1'b0;
            for (int g = 0; g < 3; g++) xa_rd_s[g] = hold[g];
            xa_addr = 16'h0040; xa_data = 16'h0000; xa_wr = 1'b0;
            wa_wr = (c == 5) || (c == 6); wa_addr = 16'h0050; wa_data = 16'h2468;
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                if (c <= 3) begin
                    if (g == 2) begin
                        e        = '0;
                        e.t_rd   = (c == 1);
                        e.addr   = (c == 1) ? 16'h0040 : 16'h0000;
                        e.busy   = (c >= 1);
                        e.xrd    = 16'h1234;
                        chk($sformatf("rst_mid_c%0d", c), g, e);
                    end
                end else begin
                    e = (c == 6) ? o_wr(16'h0050, 16'h2468, 0, 16'h0000) : o_idle(16'h0000);
                    chk($sformatf("after_rst_c%0d", c), g, e);
                end
                if (xa_ack[g]) hold[g] = 1'b0;
            end
        end

        @(posedge clk);
        #1;
        wa_wr = 1'b0;
        @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending accesses required 0", sbq.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
